// File: rtl/sd_spi_ctrl.sv
// SPI master (mode 0) for the SD card ports: init clocking, byte exchange, CS control, idle timeout.
// Optional SD_SLOWINIT_EN: cmd 0 uses INIT_DIV as the SCLK half-period instead of DIV.
module sd_spi_ctrl #(
    parameter int unsigned DIV         = 4,
    parameter int unsigned INIT_DIV    = 64,
    parameter int unsigned TIMEOUT_CYC = 2500000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       sd_signal,
    input  logic [1:0] sd_cmd,
    input  logic [7:0] sd_out,
    output logic [7:0] sd_din,
    output logic       sd_busy,
    output logic       sd_timeout,
    output logic       spi_cs,
    output logic       spi_sclk,
    output logic       spi_mosi,
    input  logic       spi_miso
);

    localparam int unsigned MAX_DIV = (DIV > INIT_DIV) ? DIV : INIT_DIV;
    localparam int unsigned DW      = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;
    localparam int unsigned TW      = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
`ifdef SD_SLOWINIT_EN
    localparam int unsigned INIT_HALF = INIT_DIV;
`else
    localparam int unsigned INIT_HALF = DIV;
`endif
    localparam logic [DW-1:0] DIV_RELOAD  = DW'(DIV - 1);
    localparam logic [DW-1:0] INIT_RELOAD = DW'(INIT_HALF - 1);
    localparam logic [TW-1:0] TOUT_MAX    = TW'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SCLK_LO = 2'd1,
        SCLK_HI = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   div_cnt_q, div_cnt_d;
    logic [6:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      tx_sr_q, tx_sr_d;
    logic [7:0]      rx_sr_q, rx_sr_d;
    logic            init_op_q, init_op_d;
    logic            cs_q, cs_d;
    logic            sclk_q, sclk_d;
    logic            mosi_q, mosi_d;
    logic [7:0]      din_q, din_d;
    logic            busy_q, busy_d;
    logic [TW-1:0]   tout_cnt_q, tout_cnt_d;
    logic            timeout_q, timeout_d;
    logic            miso_meta, miso_sync;
    logic [DW-1:0]   run_reload;

    assign run_reload = init_op_q ? INIT_RELOAD : DIV_RELOAD;

    // MISO crosses from the card; two-flop synchroniser
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            miso_meta <= 1'b1;
            miso_sync <= 1'b1;
        end else begin
            miso_meta <= spi_miso;
            miso_sync <= miso_meta;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            div_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            tx_sr_q    <= 8'hFF;
            rx_sr_q    <= 8'hFF;
            init_op_q  <= 1'b0;
            cs_q       <= 1'b1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b1;
            din_q      <= 8'hFF;
            busy_q     <= 1'b0;
            tout_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            init_op_q  <= init_op_d;
            cs_q       <= cs_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            din_q      <= din_d;
            busy_q     <= busy_d;
            tout_cnt_q <= tout_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        init_op_d  = init_op_q;
        cs_d       = cs_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        din_d      = din_q;
        busy_d     = busy_q;
        tout_cnt_d = tout_cnt_q;

        // Idle timeout: cleared by any accepted command, saturating otherwise
        if (state_q == IDLE && sd_signal) begin
            tout_cnt_d = '0;
        end else if (tout_cnt_q != TOUT_MAX) begin
            tout_cnt_d = tout_cnt_q + 1'b1;
        end
        timeout_d = (tout_cnt_d == TOUT_MAX);

        case (state_q)
            IDLE: begin
                if (sd_signal) begin
                    case (sd_cmd)
                        2'd0: begin
                            state_d   = SCLK_LO;
                            init_op_d = 1'b1;
                            cs_d      = 1'b1;
                            tx_sr_d   = 8'hFF;
                            mosi_d    = 1'b1;
                            bit_cnt_d = 7'd79;
                            div_cnt_d = INIT_RELOAD;
                            sclk_d    = 1'b0;
                            busy_d    = 1'b1;
                        end
                        2'd1: begin
                            state_d   = SCLK_LO;
                            init_op_d = 1'b0;
                            tx_sr_d   = sd_out;
                            mosi_d    = sd_out[7];
                            bit_cnt_d = 7'd7;
                            div_cnt_d = DIV_RELOAD;
                            sclk_d    = 1'b0;
                            busy_d    = 1'b1;
                        end
                        2'd2:    cs_d = 1'b0;
                        default: cs_d = 1'b1;
                    endcase
                end
            end
            SCLK_LO: begin
                if (div_cnt_q == '0) begin
                    state_d   = SCLK_HI;
                    sclk_d    = 1'b1;
                    div_cnt_d = run_reload;
                    rx_sr_d   = {rx_sr_q[6:0], miso_sync};
                end else begin
                    div_cnt_d = div_cnt_q - 1'b1;
                end
            end
            SCLK_HI: begin
                if (div_cnt_q == '0) begin
                    sclk_d    = 1'b0;
                    div_cnt_d = run_reload;
                    if (bit_cnt_q == '0) begin
                        state_d = IDLE;
                        mosi_d  = 1'b1;
                        busy_d  = 1'b0;
                        if (!init_op_q) din_d = rx_sr_q;
                    end else begin
                        state_d   = SCLK_LO;
                        bit_cnt_d = bit_cnt_q - 1'b1;
                        tx_sr_d   = {tx_sr_q[6:0], 1'b1};
                        mosi_d    = tx_sr_q[6];
                    end
                end else begin
                    div_cnt_d = div_cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign sd_din     = din_q;
    assign sd_busy    = busy_q;
    assign sd_timeout = timeout_q;
    assign spi_cs     = cs_q;
    assign spi_sclk   = sclk_q;
    assign spi_mosi   = mosi_q;

endmodule

// File: tb/tb_sd_spi_ctrl.sv
// Directed bench for sd_spi_ctrl: reset, timeout, CS control, byte exchange, dropped strobe, init clocking.
module tb_sd_spi_ctrl;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       sd_signal;
    logic [1:0] sd_cmd;
    logic [7:0] sd_out;
    logic [7:0] sd_din;
    logic       sd_busy;
    logic       sd_timeout;
    logic       spi_cs;
    logic       spi_sclk;
    logic       spi_mosi;
    logic       spi_miso;

    int n_checks = 0;
    int n_fail   = 0;
    int pulse_cnt = 0;
    int bad_cnt   = 0;
    int width;
    logic [7:0] mosi_cap = 8'h00;
    logic [7:0] card_sr  = 8'hFF;

    sd_spi_ctrl #(.DIV(4), .INIT_DIV(64), .TIMEOUT_CYC(100)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .sd_signal  (sd_signal),
        .sd_cmd     (sd_cmd),
        .sd_out     (sd_out),
        .sd_din     (sd_din),
        .sd_busy    (sd_busy),
        .sd_timeout (sd_timeout),
        .spi_cs     (spi_cs),
        .spi_sclk   (spi_sclk),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso)
    );

    always #5 clock = ~clock;

    // Capture MOSI on SCLK rises; cs/mosi must both be 1 during init
    always @(posedge spi_sclk) begin
        pulse_cnt++;
        mosi_cap = {mosi_cap[6:0], spi_mosi};
        if (spi_cs !== 1'b1 || spi_mosi !== 1'b1) bad_cnt++;
    end

    // Card model: next bit presented on SCLK fall while selected
    always @(negedge spi_sclk) begin
        if (!spi_cs) begin
            card_sr  = {card_sr[6:0], 1'b1};
            spi_miso = card_sr[7];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic strobe(input logic [1:0] cmd, input logic [7:0] data);
        @(negedge clock);
        sd_signal = 1'b1;
        sd_cmd    = cmd;
        sd_out    = data;
        @(posedge clock);
        #1;
        sd_signal = 1'b0;
    endtask

    task automatic wait_busy(input int limit, output int n);
        n = 0;
        while (sd_busy && n < limit) begin
            @(posedge clock);
            #1;
            n++;
        end
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_cs"},   32'(spi_cs),     32'd1);
        check({pfx, "_sclk"}, 32'(spi_sclk),   32'd0);
        check({pfx, "_mosi"}, 32'(spi_mosi),   32'd1);
        check({pfx, "_din"},  32'(sd_din),     32'hFF);
        check({pfx, "_busy"}, 32'(sd_busy),    32'd0);
        check({pfx, "_tout"}, 32'(sd_timeout), 32'd0);
    endtask

    initial begin
        reset_n   = 1'b0;
        sd_signal = 1'b0;
        sd_cmd    = 2'd0;
        sd_out    = 8'h00;
        spi_miso  = 1'b1;
        #22;
        check_reset_values("rst");
        @(negedge clock);
        reset_n = 1'b1;

        // Timeout rises on clock 100 after reset and holds
        repeat (99) @(posedge clock);
        #1 check("tout_99", 32'(sd_timeout), 32'd0);
        @(posedge clock);
        #1 check("tout_100", 32'(sd_timeout), 32'd1);
        repeat (20) @(posedge clock);
        #1 check("tout_hold", 32'(sd_timeout), 32'd1);
        strobe(2'd3, 8'h00);
        check("tout_clear", 32'(sd_timeout), 32'd0);

        strobe(2'd2, 8'h00);
        check("cs_select", 32'(spi_cs), 32'd0);

        // Exchange A5 out, 3C in
        card_sr = 8'h3C;
        spi_miso = card_sr[7];
        pulse_cnt = 0;
        strobe(2'd1, 8'hA5);
        check("x1_busy", 32'(sd_busy), 32'd1);
        check("x1_mosi0", 32'(spi_mosi), 32'd1);
        wait_busy(1000, width);
        check("x1_width", 32'(width), 32'd64);
        check("x1_din", 32'(sd_din), 32'h3C);
        check("x1_cs", 32'(spi_cs), 32'd0);
        check("x1_mosi_bits", 32'(mosi_cap), 32'hA5);
        check("x1_pulses", 32'(pulse_cnt), 32'd8);
        check("x1_sclk_idle", 32'(spi_sclk), 32'd0);
        check("x1_mosi_idle", 32'(spi_mosi), 32'd1);

        // Second strobe during an exchange is dropped
        card_sr = 8'hC3;
        spi_miso = card_sr[7];
        pulse_cnt = 0;
        strobe(2'd1, 8'h81);
        repeat (10) @(posedge clock);
        strobe(2'd1, 8'h00);
        wait_busy(1000, width);
        check("x2_width_rest", 32'(width), 32'd53);
        check("x2_din", 32'(sd_din), 32'hC3);
        check("x2_mosi_bits", 32'(mosi_cap), 32'h81);
        repeat (100) @(posedge clock);
        #1;
        check("x2_idle_busy", 32'(sd_busy), 32'd0);
        check("x2_pulses", 32'(pulse_cnt), 32'd8);

        // Init clocking: 80 pulses with cs=1, mosi=1
        pulse_cnt = 0;
        bad_cnt   = 0;
        strobe(2'd0, 8'h00);
        check("init_cs", 32'(spi_cs), 32'd1);
        check("init_busy", 32'(sd_busy), 32'd1);
        wait_busy(20000, width);
`ifdef SD_SLOWINIT_EN
        check("init_width", 32'(width), 32'd10240);
`else
        check("init_width", 32'(width), 32'd640);
`endif
        check("init_pulses", 32'(pulse_cnt), 32'd80);
        check("init_cs_mosi", 32'(bad_cnt), 32'd0);
        check("init_din", 32'(sd_din), 32'hC3);
        check("init_cs_after", 32'(spi_cs), 32'd1);

        // Reset mid-exchange forces idle values at once
        strobe(2'd2, 8'h00);
        strobe(2'd1, 8'h5A);
        repeat (20) @(posedge clock);
        #2 reset_n = 1'b0;
        #1 check_reset_values("midrst");
        @(negedge clock);
        reset_n = 1'b1;
        repeat (5) @(posedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
